ser_tx_scheduler: RTL and testbench
===================================

SER_TX_SCHEDULER -- requirements
Module: ser_tx_scheduler

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock; one serial bit per cycle.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester transmit request; bit i is requester i; held high until done[i].
REQ-005 len_in  input  16  byte count, 0..15; requester i on [4i+3:4i].
REQ-006 data_in  input  32  current data byte; requester i on [8i+7:8i].
REQ-007 grant  output  4  one-hot owner of the link; all zero when idle.
REQ-008 data_take  output  4  one-cycle pulse on bit i when the byte on data_in[8i+7:8i] is latched.
REQ-009 done  output  4  one-cycle pulse on bit i in the last frame cycle of requester i.
REQ-010 serOut  output  1  serial line; idle level 1.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 state  output  3  FSM state: IDLE=0, START=1, PORT=2, LEN=3, DATA=4, PAR=5, GAP=6.

Function
REQ-013 Frame format SHALL be start bit 0, 2-bit port ID MSB first, 4-bit length MSB first, then length bytes each MSB first; serOut is 1 outside frames.
REQ-014 In IDLE with any req bit set, the block SHALL select one requester round-robin, searching upward from (last granted + 1) mod 4.
REQ-015 On selection the block SHALL latch port ID and len_in, assert grant, and enter START on the next edge.
REQ-016 START SHALL last 1 cycle with serOut=0; PORT 2 cycles; LEN 4 cycles.
REQ-017 At LEN end, len=0 SHALL go to GAP; otherwise DATA.
REQ-018 In the cycle before each byte's first DATA bit, the block SHALL latch data_in of the owner and pulse its data_take bit.
REQ-019 After data_take, the requester SHALL present the next byte within 8 cycles; the block samples it 8 cycles later (9 with parity).
REQ-020 DATA SHALL last 8 cycles per byte; a byte counter decrements per byte; counter 0 after the last bit goes to GAP.
REQ-021 GAP SHALL last 1 cycle with serOut=1, pulse done, clear grant, and return to IDLE; back-to-back frames are thus separated by at least 2 idle-level cycles (GAP plus IDLE).
REQ-022 Frame latency: the first start bit SHALL appear 1 cycle after req rises in IDLE.
REQ-023 Deassertion of the owner's req mid-frame SHALL be ignored; the frame completes.
REQ-024 New or changed req bits, len_in and data_in outside sampling cycles SHALL not affect the current frame.
REQ-025 With all four requesting continuously, grants SHALL rotate 0,1,2,3,0 with no starvation.

Reset
REQ-026 On reset: state=IDLE, serOut=1, grant=0, data_take=0, done=0, busy=0, counters cleared, round-robin pointer = 3 (so port 0 wins first).
REQ-027 Reset mid-frame SHALL abort immediately; serOut goes to 1 asynchronously and no done pulse is issued.

Configuration
REQ-028 Macro SER_PARITY_EN: when defined, each data byte SHALL be followed by one PAR cycle carrying even parity (XOR of the 8 bits); frame length = 7+9N cycles.
REQ-029 Without SER_PARITY_EN, PAR SHALL never be entered; frame length = 7+8N cycles.

Verification
REQ-030 Reset, req=0001, len=1, data=0xAA -> serOut 0,00,0001,10101010 then 1; done[0] at cycle 15; data_take[0] once.
REQ-031 req=0100, len=0 -> serOut 0,10,0000 then GAP; done[2] after 8 cycles; no data_take.
REQ-032 req=1111 held, len=1 each -> grant order 0001,0010,0100,1000,0001; each frame 16 cycles incl. GAP.
REQ-033 len=3, bytes 0x12,0x34,0x56 -> three data_take pulses 8 cycles apart; serial bytes match in order.
REQ-034 Reset asserted during DATA bit 4 -> serOut=1, state=0, grant=0 immediately; next req=0001 wins port 0.
REQ-035 With SER_PARITY_EN, len=1, data=0x07 -> parity bit 1 after byte; done at cycle 16.

Source files
------------

// File: rtl/ser_tx_scheduler.sv
// Four-port round-robin serial frame transmitter: start, port ID, length, data bytes, gap.
// Optional even parity after each data byte when SER_PARITY_EN is defined.
module ser_tx_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] len_in,
    input  logic [31:0] data_in,
    output logic [3:0]  grant,
    output logic [3:0]  data_take,
    output logic [3:0]  done,
    output logic        serOut,
    output logic        busy,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        PORT  = 3'd2,
        LEN   = 3'd3,
        DATA  = 3'd4,
        PAR   = 3'd5,
        GAP   = 3'd6
    } state_t;

    state_t      st, st_nxt;
    logic [1:0]  last_q;
    logic [1:0]  sel;
    logic        sel_vld;
    logic        load_sel;
    logic        load_byte;
    logic [2:0]  cnt_q, cnt_nxt;
    logic [3:0]  left_q, left_nxt;
    logic [1:0]  port_q;
    logic [3:0]  len_q;
    logic [7:0]  byte_q;

    // Round-robin search starting just above the last granted port
    always_comb begin : rr_search
        logic [1:0] cand;
        sel     = last_q;
        sel_vld = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!sel_vld && req[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt_q;
        left_nxt  = left_q;
        load_sel  = 1'b0;
        load_byte = 1'b0;
        case (st)
            IDLE: begin
                if (sel_vld) begin
                    load_sel = 1'b1;
                    st_nxt   = START;
                end
            end
            START: begin
                st_nxt  = PORT;
                cnt_nxt = '0;
            end
            PORT: begin
                if (cnt_q == 3'd1) begin
                    st_nxt  = LEN;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_q + 3'd1;
                end
            end
            LEN: begin
                if (cnt_q == 3'd3) begin
                    cnt_nxt = '0;
                    if (len_q == 4'd0) begin
                        st_nxt = GAP;
                    end else begin
                        st_nxt    = DATA;
                        load_byte = 1'b1;
                        left_nxt  = len_q;
                    end
                end else begin
                    cnt_nxt = cnt_q + 3'd1;
                end
            end
            DATA: begin
                if (cnt_q == 3'd7) begin
                    cnt_nxt = '0;
`ifdef SER_PARITY_EN
                    st_nxt = PAR;
`else
                    if (left_q == 4'd1) begin
                        st_nxt = GAP;
                    end else begin
                        load_byte = 1'b1;
                        left_nxt  = left_q - 4'd1;
                    end
`endif
                end else begin
                    cnt_nxt = cnt_q + 3'd1;
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                if (left_q == 4'd1) begin
                    st_nxt = GAP;
                end else begin
                    st_nxt    = DATA;
                    load_byte = 1'b1;
                    left_nxt  = left_q - 4'd1;
                end
            end
`endif
            GAP:     st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= IDLE;
            cnt_q  <= '0;
            left_q <= '0;
            last_q <= 2'd3;
            grant  <= '0;
        end else begin
            st     <= st_nxt;
            cnt_q  <= cnt_nxt;
            left_q <= left_nxt;
            if (load_sel) begin
                last_q <= sel;
                grant  <= 4'b0001 << sel;
            end else if (st == GAP) begin
                grant  <= '0;
            end
        end
    end

    // Frame payload registers carry no reset; they are only read inside a frame
    always_ff @(posedge clk) begin
        if (load_sel) begin
            port_q <= sel;
            len_q  <= len_in[{sel, 2'b00} +: 4];
        end
        if (load_byte) begin
            byte_q <= data_in[{port_q, 3'b000} +: 8];
        end
    end

    always_comb begin
        serOut = 1'b1;
        case (st)
            START: serOut = 1'b0;
            PORT:  serOut = port_q[~cnt_q[0]];
            LEN:   serOut = len_q[~cnt_q[1:0]];
            DATA:  serOut = byte_q[~cnt_q];
`ifdef SER_PARITY_EN
            PAR:   serOut = ^byte_q;
`endif
            default: serOut = 1'b1;
        endcase
    end

    assign data_take = load_byte ? grant : 4'd0;
    assign done      = (st == GAP) ? grant : 4'd0;
    assign busy      = (st != IDLE);
    assign state     = st;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Randomized bench for ser_tx_scheduler with a frame-level reference model built from bit lists.
module tb_ser_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len_in;
    logic [31:0] data_in;
    logic [3:0]  grant, data_take, done;
    logic        serOut, busy;
    logic [2:0]  state;

    ser_tx_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .len_in    (len_in),
        .data_in   (data_in),
        .grant     (grant),
        .data_take (data_take),
        .done      (done),
        .serOut    (serOut),
        .busy      (busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ser;
        logic [2:0] st;
        logic [3:0] grant;
        logic [3:0] take;
        logic [3:0] done;
    } rec_t;

    rec_t       q[$];
    logic [3:0] glog[$];
    int         total = 0;
    int         bad = 0;
    int         rr;
    int         owner;
    int         p_new;
    int         renew;
    int         renew_len;
    bit         take_pend;
    logic [7:0] mem [4][16];
    int         lenr[4];
    int         bi[4];
    int         gcnt[4];
    int         rs[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t mk(logic ser, logic [2:0] st, logic [3:0] g, logic [3:0] tk, logic [3:0] dn);
        rec_t r;
        r.ser = ser; r.st = st; r.grant = g; r.take = tk; r.done = dn;
        return r;
    endfunction

    task automatic arm(input int r, input int l);
        lenr[r] = l;
        for (int k = 0; k < 16; k++) mem[r][k] = 8'($urandom);
        bi[r] = 0;
        rs[r] = 1;
    endtask

    // Expected per-cycle outputs for one whole frame, plus the idle cycle after GAP
    task automatic build(input int w);
        logic [3:0] g;
        int nb;
        g  = 4'b0001 << w;
        nb = lenr[w];
        q.push_back(mk(1'b0, 3'd1, g, 4'd0, 4'd0));
        for (int b = 1; b >= 0; b--) q.push_back(mk(1'(w >> b), 3'd2, g, 4'd0, 4'd0));
        for (int b = 3; b >= 0; b--)
            q.push_back(mk(1'(lenr[w] >> b), 3'd3, g, (b == 0 && nb > 0) ? g : 4'd0, 4'd0));
        for (int k = 0; k < nb; k++) begin
            for (int b = 7; b >= 0; b--) begin
`ifdef SER_PARITY_EN
                q.push_back(mk(mem[w][k][b], 3'd4, g, 4'd0, 4'd0));
`else
                q.push_back(mk(mem[w][k][b], 3'd4, g, (b == 0 && k < nb - 1) ? g : 4'd0, 4'd0));
`endif
            end
`ifdef SER_PARITY_EN
            q.push_back(mk(^mem[w][k], 3'd5, g, (k < nb - 1) ? g : 4'd0, 4'd0));
`endif
        end
        q.push_back(mk(1'b1, 3'd6, g, 4'd0, g));
        q.push_back(mk(1'b1, 3'd0, 4'd0, 4'd0, 4'd0));
    endtask

    task automatic drive();
        for (int r = 0; r < 4; r++) begin
            req[r] = (rs[r] == 1) ? 1'b1 : (rs[r] == 2) ? 1'($urandom_range(1)) : 1'b0;
            len_in[4*r +: 4]  = (rs[r] == 1) ? 4'(lenr[r]) : 4'($urandom);
            data_in[8*r +: 8] = (rs[r] == 2 && gcnt[r] == 0) ? mem[r][bi[r]] : 8'($urandom);
        end
    endtask

    task automatic run_cycles(input int n);
        rec_t e;
        repeat (n) begin
            for (int r = 0; r < 4; r++)
                if (rs[r] == 0 && p_new > 0 && $urandom_range(99) < p_new) arm(r, $urandom_range(15));
            drive();
            if (q.size() == 0 && req != 4'd0) begin
                for (int i = 1; i <= 4; i++) begin
                    int c;
                    c = (rr + i) % 4;
                    if (req[c]) begin
                        owner = c;
                        break;
                    end
                end
                rr = owner;
                rs[owner] = 2;
                gcnt[owner] = $urandom_range(6);
                build(owner);
            end
            @(posedge clk);
            #1;
            e = (q.size() != 0) ? q.pop_front() : mk(1'b1, 3'd0, 4'd0, 4'd0, 4'd0);
            chk("serOut", serOut, e.ser);
            chk("grant", grant, e.grant);
            chk("data_take", data_take, e.take);
            chk("done", done, e.done);
            chk("busy", busy, e.st != 3'd0);
            chk("state", state, e.st);
            if (e.st == 3'd1) glog.push_back(grant);
            if (owner >= 0) begin
                if (gcnt[owner] > 0) gcnt[owner]--;
                if (take_pend) begin
                    bi[owner]++;
                    gcnt[owner] = $urandom_range(6);
                    take_pend = 1'b0;
                end
                if (e.take != 4'd0) take_pend = 1'b1;
                if (e.done != 4'd0) begin
                    rs[owner] = 0;
                    if (renew == 1) arm(owner, renew_len);
                    else if (renew == 2 && $urandom_range(2) == 0) arm(owner, $urandom_range(15));
                    owner = -1;
                end
            end
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((q.size() != 0 || rs[0] != 0 || rs[1] != 0 || rs[2] != 0 || rs[3] != 0) && n < limit) begin
            run_cycles(1);
            n++;
        end
        chk("drain_idle", {busy, grant}, 5'd0);
    endtask

    initial begin
        reset = 1'b1; req = '0; len_in = '0; data_in = '0;
        p_new = 0; renew = 0; renew_len = 0; owner = -1; rr = 3; take_pend = 1'b0;
        for (int r = 0; r < 4; r++) begin rs[r] = 0; bi[r] = 0; gcnt[r] = 0; lenr[r] = 0; end
        #12;
        chk("rst_serOut", serOut, 1'b1);
        chk("rst_grant", grant, 4'd0);
        chk("rst_take", data_take, 4'd0);
        chk("rst_done", done, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", state, 3'd0);
        @(negedge clk);
        reset = 1'b0;

        arm(0, 1); mem[0][0] = 8'hAA; drain(60);
        arm(2, 0); drain(60);
        arm(1, 3); mem[1][0] = 8'h12; mem[1][1] = 8'h34; mem[1][2] = 8'h56; drain(100);
        arm(3, 1); mem[3][0] = 8'h07; drain(60);
        arm(3, 15); drain(300);

        // Abort a frame on port 0 in the middle of its first data byte
        arm(0, 2);
        run_cycles(12);
        #3 reset = 1'b1;
        #1;
        chk("abort_serOut", serOut, 1'b1);
        chk("abort_state", state, 3'd0);
        chk("abort_grant", grant, 4'd0);
        chk("abort_done", done, 4'd0);
        q.delete(); glog.delete();
        rr = 3; owner = -1; take_pend = 1'b0;
        for (int r = 0; r < 4; r++) rs[r] = 0;
        @(posedge clk);
        #1;
        chk("abort_hold_serOut", serOut, 1'b1);
        reset = 1'b0;

        // All four requesting continuously after reset: rotation must start at port 0
        for (int r = 0; r < 4; r++) arm(r, 1);
        renew = 1; renew_len = 1;
        run_cycles(80);
        renew = 0;
        drain(200);
        chk("rot_count", (glog.size() >= 5), 1'b1);
        if (glog.size() >= 5) begin
            chk("rot0", glog[0], 4'b0001);
            chk("rot1", glog[1], 4'b0010);
            chk("rot2", glog[2], 4'b0100);
            chk("rot3", glog[3], 4'b1000);
            chk("rot4", glog[4], 4'b0001);
        end

        p_new = 8; renew = 2;
        run_cycles(3000);
        p_new = 0; renew = 0;
        drain(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
